cp0_multi_irq: RTL and testbench
================================

CP0_MULTI_IRQ -- requirements
Module: cp0_multi_irq

Interface
REQ-001 Parameter WIDTH, default 64: data/register width; PC width is WIDTH-2.
REQ-002 Parameter NUM_IRQ, default 6: external interrupt lines, legal range 1..8.
REQ-003 Parameters STATUS_REG/CAUSE_REG/EPC_REG/COUNT_REG/COMPARE_REG, defaults 12/13/14/9/11: register numbers.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wr_data  in  WIDTH  MTC0 write data.
REQ-007 regnum  in  5  register select for read and write.
REQ-008 next_pc  in  WIDTH-2  word PC saved to EPC on interrupt.
REQ-009 MTC0  in  1  write wr_data to regnum this cycle.
REQ-010 ERET  in  1  return from exception.
REQ-011 irq  in  NUM_IRQ  level-sensitive interrupt requests.
REQ-012 rd_data  out  WIDTH  combinational read of register regnum; unmapped regnum reads 0.
REQ-013 EPC  out  WIDTH-2  current EPC register.
REQ-014 TakenInterrupt  out  1  redirect fetch to handler this cycle.

Function
REQ-015 Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; all other bits SHALL read 0 and ignore writes.
REQ-016 Cause: bits[8+NUM_IRQ-1:8] IP, bits[18:16] ID; all other bits SHALL read 0; Cause SHALL NOT be writable by MTC0.
REQ-017 IP SHALL register (irq | timer-pending vector) every cycle (one-cycle latency); no IP bit is sticky.
REQ-018 TakenInterrupt SHALL equal IE & ~EXL & |(IP & IM), derived from registered state only.
REQ-019 On an edge with TakenInterrupt=1: EXL<=1, EPC<=next_pc, ID<=highest-index bit set in IP & IM.
REQ-020 With EXL=1, TakenInterrupt SHALL stay 0, so it is high for exactly one cycle per entry and EPC is not overwritten.
REQ-021 ERET SHALL clear EXL at the next edge; ERET with EXL=0 has no effect.
REQ-022 MTC0 to EPC_REG SHALL load wr_data[WIDTH-3:0] into EPC.
REQ-023 Same-edge TakenInterrupt and MTC0 to STATUS_REG: IE/IM take wr_data; EXL SHALL be 1.
REQ-024 Same-edge TakenInterrupt and MTC0 to EPC_REG: EPC SHALL take next_pc.
REQ-025 Same-edge TakenInterrupt and ERET: interrupt wins; EXL SHALL be 1.

Reset
REQ-026 Reset SHALL clear Status, Cause, EPC, Count, Compare and timer-pending immediately; rd_data for every register and TakenInterrupt are 0 while reset is high.
REQ-027 Reset asserted mid-handler SHALL clear EXL; no interrupt is taken until IE is rewritten.

Configuration
REQ-028 Macro CP0_COUNT_COMPARE_EN defined: Count increments by 1 every cycle, wrapping at 2^32; Count/Compare are 32-bit and MTC0-writable (MTC0 to Count has priority over the increment).
REQ-029 With the macro: timer-pending SHALL set on the edge where Count==Compare, hold until MTC0 to COMPARE_REG clears it, and OR into vector bit NUM_IRQ-1.
REQ-030 Without the macro: Count/Compare read 0, writes are ignored, and timer-pending is 0.

Structure
REQ-031 Package cp0_pkg SHALL hold the register-number defaults, Status/Cause bit positions, and the ID field width.
REQ-032 Count/Compare logic SHALL live in sub-module cp0_timer, instantiated only under CP0_COUNT_COMPARE_EN.

Verification
REQ-033 MTC0 Status with wr_data=0xffffffff, NUM_IRQ=6 -> next cycle read Status = 0x00003f01.
REQ-034 IE=1, IM=all, irq=6'b000101, next_pc=0x100001 -> TakenInterrupt high for exactly one cycle; EPC=0x100001; Cause=0x00020500; Status=0x3f03; next_pc=0x100002 afterwards leaves EPC unchanged.
REQ-035 ERET with irq=0 -> Status=0x3f01, Cause=0x00020000; with an irq held high, TakenInterrupt reasserts the cycle after EXL clears.
REQ-036 IE=0, or IM bit cleared for the only active line -> TakenInterrupt stays 0 while IP still reflects irq.
REQ-037 With the macro: Compare=5 after reset, IE=1, IM[13]=1 -> interrupt taken with ID=5; MTC0 Compare clears IP bit 13.
REQ-038 Reset asserted while EXL=1 and EPC=0x1234 -> Status, Cause and EPC read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 interrupt block: default register numbers,
// Status/Cause field positions, ID field width and the highest-pending-line
// encoder used to fill Cause.ID.
package cp0_pkg;

    // Default coprocessor-0 register numbers
    localparam int STATUS_REG_DEF  = 12;
    localparam int CAUSE_REG_DEF   = 13;
    localparam int EPC_REG_DEF     = 14;
    localparam int COUNT_REG_DEF   = 9;
    localparam int COMPARE_REG_DEF = 11;

    // Status fields
    localparam int IE_BIT  = 0;
    localparam int EXL_BIT = 1;
    localparam int IM_LSB  = 8;

    // Cause fields
    localparam int IP_LSB  = 8;
    localparam int ID_LSB  = 16;
    localparam int ID_W    = 3;

    // Count/Compare width
    localparam int TIMER_W = 32;

    // Index of the highest set bit; 0 when nothing is set.
    function automatic logic [ID_W-1:0] hi_index(input logic [7:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs and wraps at 2^32, pending latches when
// Count==Compare and is acknowledged by a Compare write.
// Latency: pending rises on the edge where Count==Compare. No backpressure.
// Ports: i_wr_count/i_wr_compare select the MTC0 target, i_wr_data is the write
// value, o_count/o_compare/o_pending expose the registered state.
// The whole module only exists when CP0_COUNT_COMPARE_EN is defined, so the
// default build carries no stray top-level module.
`ifdef CP0_COUNT_COMPARE_EN
module cp0_timer
    import cp0_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_wr_count,
    input  logic               i_wr_compare,
    input  logic [TIMER_W-1:0] i_wr_data,
    output logic [TIMER_W-1:0] o_count,
    output logic [TIMER_W-1:0] o_compare,
    output logic               o_pending
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] r_compare;
    logic               r_pending;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_pending <= 1'b0;
        end else begin
            // A software write to Count overrides the increment
            r_count <= i_wr_count ? i_wr_data : r_count + 1'b1;
            if (i_wr_compare) r_compare <= i_wr_data;
            // Writing Compare is the acknowledge, so it beats a coincident match
            if (i_wr_compare)                r_pending <= 1'b0;
            else if (r_count == r_compare)   r_pending <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule
`endif

// File: rtl/cp0_multi_irq.sv
// CP0 multi-line interrupt controller: Status/Cause/EPC registers, level-sensitive
// IRQ sampling into Cause.IP and a one-cycle TakenInterrupt redirect pulse.
// Latency: irq -> IP one cycle; TakenInterrupt is combinational from registered
// state; rd_data is a combinational read. No backpressure.
// Ports: clock/reset (async, active-high); wr_data/regnum/MTC0 register write;
// ERET exception return; next_pc saved to EPC on entry; irq level requests;
// rd_data register read; EPC current EPC; TakenInterrupt fetch redirect.
// Optional: CP0_COUNT_COMPARE_EN adds the Count/Compare timer on line NUM_IRQ-1.
module cp0_multi_irq
    import cp0_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int NUM_IRQ     = 6,
    parameter int STATUS_REG  = STATUS_REG_DEF,
    parameter int CAUSE_REG   = CAUSE_REG_DEF,
    parameter int EPC_REG     = EPC_REG_DEF,
    parameter int COUNT_REG   = COUNT_REG_DEF,
    parameter int COMPARE_REG = COMPARE_REG_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [4:0]         regnum,
    input  logic [WIDTH-3:0]   next_pc,
    input  logic               MTC0,
    input  logic               ERET,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-3:0]   EPC,
    output logic               TakenInterrupt
);

    logic               r_ie;
    logic               r_exl;
    logic [NUM_IRQ-1:0] r_im;
    logic [NUM_IRQ-1:0] r_ip;
    logic [ID_W-1:0]    r_id;
    logic [WIDTH-3:0]   r_epc;

    logic               w_wr_status;
    logic               w_wr_epc;
    logic               w_taken;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_tvec;
    logic [TIMER_W-1:0] w_count;
    logic [TIMER_W-1:0] w_compare;
    logic [WIDTH-1:0]   w_status;
    logic [WIDTH-1:0]   w_cause;
    logic               w_unused;

    assign w_wr_status = MTC0 && (regnum == 5'(STATUS_REG));
    assign w_wr_epc    = MTC0 && (regnum == 5'(EPC_REG));
    assign w_pend      = r_ip & r_im;
    assign w_taken     = r_ie & ~r_exl & (|w_pend);

`ifdef CP0_COUNT_COMPARE_EN
    logic w_tpend;

    cp0_timer u_timer (
        .clock        (clock),
        .reset        (reset),
        .i_wr_count   (MTC0 && (regnum == 5'(COUNT_REG))),
        .i_wr_compare (MTC0 && (regnum == 5'(COMPARE_REG))),
        .i_wr_data    (wr_data[TIMER_W-1:0]),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pending    (w_tpend)
    );

    // Timer request shares the top interrupt line
    always_comb begin
        w_tvec              = '0;
        w_tvec[NUM_IRQ-1]   = w_tpend;
    end
`else
    assign w_count   = '0;
    assign w_compare = '0;
    assign w_tvec    = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_im  <= '0;
            r_ip  <= '0;
            r_id  <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= irq | w_tvec;
            // EXL is not software-writable; only IE and IM take MTC0 data
            if (w_wr_status) begin
                r_ie <= wr_data[IE_BIT];
                r_im <= wr_data[IM_LSB +: NUM_IRQ];
            end
            // Interrupt entry outranks ERET and an EPC write on the same edge
            if (w_taken) begin
                r_exl <= 1'b1;
                r_epc <= next_pc;
                r_id  <= hi_index(8'(w_pend));
            end else begin
                if (ERET)     r_exl <= 1'b0;
                if (w_wr_epc) r_epc <= wr_data[WIDTH-3:0];
            end
        end
    end

    always_comb begin
        w_status                      = '0;
        w_status[IE_BIT]              = r_ie;
        w_status[EXL_BIT]             = r_exl;
        w_status[IM_LSB +: NUM_IRQ]   = r_im;
        w_cause                       = '0;
        w_cause[IP_LSB +: NUM_IRQ]    = r_ip;
        w_cause[ID_LSB +: ID_W]       = r_id;
    end

    always_comb begin
        rd_data = '0;
        if      (regnum == 5'(STATUS_REG))  rd_data = w_status;
        else if (regnum == 5'(CAUSE_REG))   rd_data = w_cause;
        else if (regnum == 5'(EPC_REG))     rd_data = WIDTH'(r_epc);
        else if (regnum == 5'(COUNT_REG))   rd_data = WIDTH'(w_count);
        else if (regnum == 5'(COMPARE_REG)) rd_data = WIDTH'(w_compare);
    end

    assign EPC            = r_epc;
    assign TakenInterrupt = w_taken;

    // Top two write-data bits have no destination
    assign w_unused = ^wr_data[WIDTH-1:WIDTH-2];

endmodule

// File: tb/tb_cp0_multi_irq.sv
module tb_cp0_multi_irq;

    localparam int WIDTH   = 64;
    localparam int NUM_IRQ = 6;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;
    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;

    logic               clock = 1'b0;
    logic               reset;
    logic [WIDTH-1:0]   wr_data;
    logic [4:0]         regnum;
    logic [WIDTH-3:0]   next_pc;
    logic               MTC0;
    logic               ERET;
    logic [NUM_IRQ-1:0] irq;
    logic [WIDTH-1:0]   rd_data;
    logic [WIDTH-3:0]   EPC;
    logic               TakenInterrupt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    cp0_multi_irq #(.WIDTH(WIDTH), .NUM_IRQ(NUM_IRQ)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_data        (wr_data),
        .regnum         (regnum),
        .next_pc        (next_pc),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .irq            (irq),
        .rd_data        (rd_data),
        .EPC            (EPC),
        .TakenInterrupt (TakenInterrupt)
    );

    // ---------------- behavioural model (architectural view) ----------------
    bit              m_ie, m_exl;
    int unsigned     m_im, m_ip, m_id;
    longint unsigned m_epc;
    int unsigned     m_cnt, m_cmp;
    bit              m_tp;

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_id = 0; m_epc = 0;
        m_cnt = 0; m_cmp = 0; m_tp = 0;
    endtask

    function automatic bit model_taken();
        return m_ie && !m_exl && ((m_ip & m_im) != 0);
    endfunction

    function automatic logic [63:0] reg_val(input logic [4:0] r);
        logic [63:0] v;
        v = 64'd0;
        if (r == R_STATUS)
            v = 64'(m_ie) + 64'(m_exl) * 2 + 64'(m_im) * 256;
        else if (r == R_CAUSE)
            v = 64'(m_ip) * 256 + 64'(m_id) * 65536;
        else if (r == R_EPC)
            v = m_epc;
`ifdef CP0_COUNT_COMPARE_EN
        else if (r == R_COUNT)
            v = 64'(m_cnt);
        else if (r == R_COMPARE)
            v = 64'(m_cmp);
`endif
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("rd_data", rd_data, reg_val(regnum));
        cmp("TakenInterrupt", 64'(TakenInterrupt), 64'(model_taken()));
        cmp("EPC", 64'(EPC), m_epc);
    endtask

    // Advance one clock: model computes architectural next state from the
    // current inputs, then outputs are compared at the falling edge.
    task automatic step();
        bit              tk, n_ie, n_exl, n_tp;
        int unsigned     n_im, n_ip, n_id, n_cnt, n_cmp, pend;
        longint unsigned n_epc;
        bit              wr_cmp;
        tk    = model_taken();
        n_ie  = m_ie;  n_exl = m_exl; n_im = m_im; n_id = m_id; n_epc = m_epc;
        n_ip  = int'(irq);
        n_cnt = m_cnt; n_cmp = m_cmp; n_tp = m_tp;
`ifdef CP0_COUNT_COMPARE_EN
        wr_cmp = MTC0 && regnum == R_COMPARE;
        n_cnt  = (MTC0 && regnum == R_COUNT) ? int'(wr_data[31:0]) : m_cnt + 1;
        n_cmp  = wr_cmp ? int'(wr_data[31:0]) : m_cmp;
        n_tp   = wr_cmp ? 1'b0 : (m_cnt == m_cmp) ? 1'b1 : m_tp;
        if (m_tp) n_ip = n_ip | (1 << (NUM_IRQ - 1));
`else
        wr_cmp = 1'b0;
`endif
        if (MTC0 && regnum == R_STATUS) begin
            n_ie = wr_data[0];
            n_im = int'((wr_data >> 8) % (64'd1 << NUM_IRQ));
        end
        if (tk) begin
            n_exl = 1;
            n_epc = next_pc;
            pend  = m_ip & m_im;
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if ((pend >> i) % 2 == 1) begin
                    n_id = i;
                    break;
                end
            end
        end else begin
            if (ERET) n_exl = 0;
            if (MTC0 && regnum == R_EPC) n_epc = wr_data % (64'd1 << (WIDTH - 2));
        end
        @(posedge clock);
        m_ie = n_ie; m_exl = n_exl; m_im = n_im; m_ip = n_ip; m_id = n_id; m_epc = n_epc;
        m_cnt = n_cnt; m_cmp = n_cmp; m_tp = n_tp;
        @(negedge clock);
        check_all();
    endtask

    task automatic peek(input logic [4:0] r, input string name, input logic [63:0] exp);
        regnum = r;
        #1;
        cmp(name, rd_data, exp);
    endtask

    task automatic write(input logic [4:0] r, input logic [63:0] d);
        MTC0 = 1; regnum = r; wr_data = d;
        step();
        MTC0 = 0;
    endtask

    logic [4:0] reg_tab [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31, 5'd5};

    initial begin
        model_reset();
        reset = 1; MTC0 = 0; ERET = 0; irq = '0; wr_data = '0; regnum = R_STATUS; next_pc = '0;
        repeat (2) @(negedge clock);
        cmp("reset_status", rd_data, 64'h0);
        cmp("reset_taken", 64'(TakenInterrupt), 64'h0);
        reset = 0;
        @(negedge clock);

        // Status write masks unimplemented bits, EXL not writable
        write(R_STATUS, 64'hffff_ffff);
        cmp("status_write", rd_data, 64'h3f01);

        // Entry: one-cycle pulse, EPC capture, ID = highest pending line
        irq = 6'b000101; next_pc = 62'h100001;
        step();
        cmp("taken_pulse", 64'(TakenInterrupt), 64'h1);
        step();
        cmp("taken_drop", 64'(TakenInterrupt), 64'h0);
        cmp("epc_entry", 64'(EPC), 64'h100001);
        peek(R_CAUSE, "cause_entry", 64'h20500);
        peek(R_STATUS, "status_entry", 64'h3f03);
        next_pc = 62'h100002;
        step();
        cmp("epc_hold", 64'(EPC), 64'h100001);

        // ERET with irq still held: re-entry the cycle after EXL clears
        ERET = 1;
        step();
        ERET = 0;
        cmp("reentry", 64'(TakenInterrupt), 64'h1);
        step();
        irq = '0;
        step();
        ERET = 1;
        step();
        ERET = 0;
        peek(R_STATUS, "status_eret", 64'h3f01);
        peek(R_CAUSE, "cause_eret", 64'h20000);

        // Masking: IE=0, then IM bit cleared for the only active line
        write(R_STATUS, 64'h3f00);
        irq = 6'b000001;
        step();
        cmp("ie_off", 64'(TakenInterrupt), 64'h0);
        peek(R_CAUSE, "ip_ie_off", 64'h20100);
        write(R_STATUS, 64'h3e01);
        step();
        cmp("im_off", 64'(TakenInterrupt), 64'h0);
        peek(R_CAUSE, "ip_im_off", 64'h20100);

        // Asynchronous reset mid-handler
        write(R_STATUS, 64'h3f01);
        next_pc = 62'h1234;
        step();
        cmp("epc_pre_reset", 64'(EPC), 64'h1234);
        #2;
        reset = 1;
        #1;
        cmp("async_epc", 64'(EPC), 64'h0);
        peek(R_STATUS, "async_status", 64'h0);
        peek(R_CAUSE, "async_cause", 64'h0);
        cmp("async_taken", 64'(TakenInterrupt), 64'h0);
        model_reset();
        @(negedge clock);
        check_all();
        reset = 0;
        repeat (3) step();
        cmp("no_irq_after_reset", 64'(TakenInterrupt), 64'h0);

`ifdef CP0_COUNT_COMPARE_EN
        // Timer on top line: fires at Count==5, Compare write acknowledges
        irq = '0;
        write(R_COMPARE, 64'd5);
        write(R_STATUS, 64'h2001);
        begin
            int budget = 40;
            while (!TakenInterrupt && budget > 0) begin
                step();
                budget--;
            end
            cmp("timer_fired", 64'(budget > 0), 64'h1);
        end
        step();
        peek(R_CAUSE, "timer_id", 64'h52000);
        write(R_COMPARE, 64'd1000);
        step();
        peek(R_CAUSE, "timer_ack", 64'h50000);
`endif

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            MTC0    = ($urandom_range(0, 3) == 0);
            regnum  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : reg_tab[$urandom_range(0, 7)];
            wr_data = {$urandom, $urandom};
            ERET    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) irq = NUM_IRQ'($urandom);
            next_pc = 62'({$urandom, $urandom});
            step();
        end
        MTC0 = 0; ERET = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
